// File: rtl/pll_rst_pkg.sv
// Shared types for the PLL reset sequencer: FSM states, reset-cause codes and a sizing helper.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    REL_CORE,
    RUN,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR       = 2'd0,
    CAUSE_LOCK_LOSS = 2'd1,
    CAUSE_EXT       = 2'd2
  } rst_cause_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_ff.sv
// N-stage flop synchronizer with asynchronous active-low reset; output resets to 0.
module sync_ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Staged core/peripheral reset sequencer behind the PLL, with lock-loss and external re-entry.
// Define PLL_RST_LOCK_LOSS_CNT_EN to implement the saturating lock_loss_cnt; otherwise it reads 0.
module pll_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP_CYCLES   = 16,
  parameter int unsigned HOLD_CYCLES        = 64,
  parameter int unsigned CNT_W              = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             ext_rst_req,
  output logic             sys_rst_n,
  output logic             periph_rst_n,
  output logic             ready,
  output logic [1:0]       rst_cause,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned TW =
      $clog2(max3(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [TW-1:0] LockLast = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] GapLast  = TW'(STAGE_GAP_CYCLES - 1);
  localparam logic [TW-1:0] HoldLast = TW'(HOLD_CYCLES - 1);

  logic          locked_s;
  logic          in_qual;
  logic          lock_loss_ev;
  state_e        state_q;
  logic [TW-1:0] cnt_q;
  logic          sys_q, periph_q, ready_q;
  rst_cause_e    cause_q;

  sync_ff #(
    .Stages(SYNC_STAGES)
  ) u_sync_locked (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  assign in_qual      = (state_q == STABLE) || (state_q == REL_CORE) || (state_q == RUN);
  assign lock_loss_ev = !locked_s && ((state_q == REL_CORE) || (state_q == RUN));

  // Lock loss is checked before the external request so it wins a same-cycle collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      sys_q    <= 1'b0;
      periph_q <= 1'b0;
      ready_q  <= 1'b0;
      cause_q  <= CAUSE_POR;
    end else if (in_qual && !locked_s) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      sys_q    <= 1'b0;
      periph_q <= 1'b0;
      ready_q  <= 1'b0;
      if (lock_loss_ev) cause_q <= CAUSE_LOCK_LOSS;
    end else if (in_qual && ext_rst_req) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      sys_q    <= 1'b0;
      periph_q <= 1'b0;
      ready_q  <= 1'b0;
      cause_q  <= CAUSE_EXT;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          cnt_q <= '0;
          if (locked_s) begin
            // The cycle that leaves WAIT_LOCK is the first qualified locked cycle.
            if (LOCK_STABLE_CYCLES == 1) begin
              state_q <= REL_CORE;
              sys_q   <= 1'b1;
            end else begin
              state_q <= STABLE;
              cnt_q   <= TW'(1);
            end
          end
        end
        STABLE: begin
          if (cnt_q == LockLast) begin
            state_q <= REL_CORE;
            cnt_q   <= '0;
            sys_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REL_CORE: begin
          if (cnt_q == GapLast) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        HOLD: begin
          if (cnt_q == HoldLast) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sys_rst_n    = sys_q;
  assign periph_rst_n = periph_q;
  assign ready        = ready_q;
  assign rst_cause    = cause_q;

`ifdef PLL_RST_LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if (lock_loss_ev && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench: directed scenarios plus randomized lock/request traffic against a
// cycle model built from consecutive-lock streak and hold-time arithmetic.
module tb_pll_reset_seq;

  localparam int SYNC = 2;
  localparam int L    = 16;
  localparam int G    = 4;
  localparam int H    = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PLL_RST_LOCK_LOSS_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pll_locked = 1'b0;
  logic          ext_rst_req = 1'b0;
  logic          sys_rst_n, periph_rst_n, ready;
  logic [1:0]    rst_cause;
  logic [CW-1:0] lock_loss_cnt;

  pll_reset_seq #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(L),
    .STAGE_GAP_CYCLES  (G),
    .HOLD_CYCLES       (H),
    .CNT_W             (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .ext_rst_req  (ext_rst_req),
    .sys_rst_n    (sys_rst_n),
    .periph_rst_n (periph_rst_n),
    .ready        (ready),
    .rst_cause    (rst_cause),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: streak = consecutive synchronized-locked cycles since the last
  // re-entry, hold_left = remaining external-hold cycles.
  bit lq[$];
  int streak, hold_left, m_cause, m_cnt;

  task automatic model_reset();
    streak = 0;
    hold_left = 0;
    m_cause = 0;
    m_cnt = 0;
    lq.delete();
    for (int i = 0; i < SYNC; i++) lq.push_back(1'b0);
  endtask

  initial begin
    bit ls;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        ls = lq.pop_front();
        lq.push_back(pll_locked);
        if (hold_left > 0) begin
          hold_left--;
        end else if (streak == 0) begin
          if (ls) streak = 1;
        end else if (!ls) begin
          if (streak >= L) begin
            m_cause = 1;
            if (m_cnt < CMAX) m_cnt++;
          end
          streak = 0;
        end else if (ext_rst_req) begin
          hold_left = H;
          m_cause = 2;
          streak = 0;
        end else if (streak < L + G) begin
          streak++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("cyc_sys_rst_n", 32'(sys_rst_n), 32'(streak >= L));
        check("cyc_periph_rst_n", 32'(periph_rst_n), 32'(streak >= L + G));
        check("cyc_ready", 32'(ready), 32'(streak >= L + G));
        check("cyc_rst_cause", 32'(rst_cause), 32'(m_cause));
        check("cyc_lock_loss_cnt", 32'(lock_loss_cnt), CNT_ON ? 32'(m_cnt) : 32'd0);
        if (periph_rst_n && !sys_rst_n) check("cyc_order", 32'(sys_rst_n), 32'd1);
      end
    end
  end

  task automatic drv();
    @(negedge clk);
    #2;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Edge index (from now) at which each reset first reads released; -1 if never.
  task automatic measure(output int se, output int pe);
    se = -1;
    pe = -1;
    for (int n = 1; n <= 80; n++) begin
      edge1();
      if (se < 0 && sys_rst_n) se = n;
      if (pe < 0 && periph_rst_n) begin
        pe = n;
        break;
      end
    end
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 200 && !ready; n++) edge1();
    check("wait_ready", 32'(ready), 32'd1);
  endtask

  task automatic por();
    drv();
    rst_n = 1'b0;
    drv();
    drv();
    rst_n = 1'b1;
  endtask

  int se, pe, seg, exp_cnt;

  initial begin
    #1 rst_n = 1'b0;
    started = 1'b1;
    pll_locked = 1'b1;
    drv();
    drv();
    check("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    check("rst_periph_rst_n", 32'(periph_rst_n), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_cause_por", 32'(rst_cause), 32'd0);
    check("rst_lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    drv();
    rst_n = 1'b1;
    measure(se, pe);
    check("por_sys_edge", 32'(se), 32'd18);
    check("por_periph_edge", 32'(pe), 32'd22);
    check("por_ready", 32'(ready), 32'd1);
    check("por_cause", 32'(rst_cause), 32'd0);

    // One-cycle dropout while qualifying restarts the count without touching cause/count.
    por();
    for (int n = 1; n <= 10; n++) @(posedge clk);
    #3 pll_locked = 1'b0;
    @(posedge clk);
    #3 pll_locked = 1'b1;
    measure(se, pe);
    check("glitch_sys_edge", 32'(se + 11), 32'd29);
    check("glitch_cnt", 32'(lock_loss_cnt), 32'd0);
    check("glitch_cause", 32'(rst_cause), 32'd0);

    // Lock loss from RUN.
    drv();
    pll_locked = 1'b0;
    edge1();
    check("loss_e1_sys", 32'(sys_rst_n), 32'd1);
    edge1();
    check("loss_e2_sys", 32'(sys_rst_n), 32'd1);
    edge1();
    check("loss_e3_sys", 32'(sys_rst_n), 32'd0);
    check("loss_e3_periph", 32'(periph_rst_n), 32'd0);
    check("loss_e3_ready", 32'(ready), 32'd0);
    check("loss_cause", 32'(rst_cause), 32'd1);
    check("loss_cnt", 32'(lock_loss_cnt), CNT_ON ? 32'd1 : 32'd0);
    drv();
    pll_locked = 1'b1;
    measure(se, pe);
    check("relock_sys_edge", 32'(se), 32'd18);
    check("relock_periph_edge", 32'(pe), 32'd22);

    // External request from RUN.
    drv();
    ext_rst_req = 1'b1;
    edge1();
    check("ext_sys", 32'(sys_rst_n), 32'd0);
    check("ext_periph", 32'(periph_rst_n), 32'd0);
    check("ext_cause", 32'(rst_cause), 32'd2);
    drv();
    ext_rst_req = 1'b0;
    measure(se, pe);
    check("ext_sys_edge", 32'(se), 32'd24);
    check("ext_periph_edge", 32'(pe), 32'd28);
    check("ext_cnt", 32'(lock_loss_cnt), CNT_ON ? 32'd1 : 32'd0);

    // Request lands on the same cycle the synchronized lock falls.
    drv();
    pll_locked = 1'b0;
    @(posedge clk);
    @(posedge clk);
    drv();
    ext_rst_req = 1'b1;
    edge1();
    check("coll_sys", 32'(sys_rst_n), 32'd0);
    check("coll_cause", 32'(rst_cause), 32'd1);
    drv();
    ext_rst_req = 1'b0;
    pll_locked = 1'b1;
    wait_ready();

    // Two more losses: four in total, saturating a 2-bit counter.
    for (int k = 0; k < 2; k++) begin
      drv();
      pll_locked = 1'b0;
      repeat (4) @(posedge clk);
      drv();
      pll_locked = 1'b1;
      if (k == 0) wait_ready();
    end
    exp_cnt = CNT_ON ? CMAX : 0;
    check("sat_cnt", 32'(lock_loss_cnt), 32'(exp_cnt));

    // Asynchronous reset while in the core-released / peripheral-held window.
    for (int n = 0; n < 100 && !(sys_rst_n && !periph_rst_n); n++) edge1();
    check("relcore_reached", 32'(sys_rst_n && !periph_rst_n), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_sys", 32'(sys_rst_n), 32'd0);
    check("arst_periph", 32'(periph_rst_n), 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_cause", 32'(rst_cause), 32'd0);
    check("arst_cnt", 32'(lock_loss_cnt), 32'd0);
    drv();
    rst_n = 1'b1;

    // Randomized traffic, checked every cycle by the model.
    for (int s = 0; s < 120; s++) begin
      seg = pll_locked ? $urandom_range(1, 6) : $urandom_range(5, 80);
      pll_locked = ~pll_locked;
      for (int c = 0; c < seg; c++) begin
        drv();
        ext_rst_req = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 1999) == 0) begin
          rst_n = 1'b0;
          drv();
          rst_n = 1'b1;
        end
      end
    end
    drv();
    ext_rst_req = 1'b0;
    drv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sits directly downstream of the ECP5 PLL wrapper.
- Consumes the PLL's async `locked` flag and runs in the PLL output clock domain (50 MHz).
- Generates staged, glitch-free resets for the SoC: core reset first, peripheral reset STAGE_GAP_CYCLES later.
- Re-enters reset on PLL lock loss or on an external reset request; reports the cause.

Parameters:
- SYNC_STAGES, 2, flop depth of the pll_locked synchronizer (legal range 2..4).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before core reset release (>=1).
- STAGE_GAP_CYCLES, 16, cycles between sys_rst_n release and periph_rst_n release (>=1).
- HOLD_CYCLES, 64, minimum reset assertion after an external request (>=1).
- CNT_W, 8, width of the lock-loss event counter.

Ports:
- clk  in  1  PLL output clock (50 MHz).
- rst_n  in  1  reset, asynchronous assert, active-low (power-on/button).
- pll_locked  in  1  PLL LOCK, asynchronous to clk.
- ext_rst_req  in  1  synchronous single-cycle reset request (debug/watchdog).
- sys_rst_n  out  1  core reset, active-low, registered.
- periph_rst_n  out  1  peripheral reset, active-low, registered.
- ready  out  1  high only in RUN.
- rst_cause  out  2  last reset cause: 0 POR, 1 LOCK_LOSS, 2 EXT.
- lock_loss_cnt  out  CNT_W  saturating count of lock-loss events.

Behaviour:
- Reset (rst_n low):
  - All outputs driven asynchronously: sys_rst_n=0, periph_rst_n=0, ready=0, rst_cause=0, lock_loss_cnt=0.
  - Synchronizer flops reset to 0; state=WAIT_LOCK; counter=0.
- Synchronizer: locked_s is pll_locked after SYNC_STAGES flops; all FSM decisions use locked_s only.
- WAIT_LOCK: counter cleared. locked_s=1 -> STABLE.
- STABLE:
  - Counter increments while locked_s=1.
  - When counter reaches LOCK_STABLE_CYCLES-1 with locked_s=1 -> REL_CORE; sys_rst_n=1 from that edge.
- REL_CORE: counter counts STAGE_GAP_CYCLES; on the last cycle -> RUN; periph_rst_n=1 and ready=1 from that edge.
- RUN: steady state; all resets released.
- Lock loss:
  - locked_s=0 in STABLE, REL_CORE or RUN -> next edge: state WAIT_LOCK; sys_rst_n=0, periph_rst_n=0, ready=0.
  - If the state was REL_CORE or RUN: rst_cause=1 and lock_loss_cnt increments.
  - Loss during STABLE just restarts qualification; cause and count unchanged.
- External request:
  - ext_rst_req=1 in STABLE, REL_CORE or RUN -> HOLD; outputs asserted next edge; rst_cause=2.
  - HOLD lasts exactly HOLD_CYCLES cycles regardless of locked_s, then WAIT_LOCK.
  - ext_rst_req is ignored in WAIT_LOCK and HOLD.
- Simultaneous lock loss and ext_rst_req: lock loss wins (WAIT_LOCK, cause 1).
- Ordering invariant: periph_rst_n=1 implies sys_rst_n=1 on every cycle. Both resets always assert on the same edge.
- Latency, pll_locked held high from rst_n release: sys_rst_n rises at edge SYNC_STAGES+LOCK_STABLE_CYCLES; periph_rst_n rises STAGE_GAP_CYCLES edges later.
- Counter width: $clog2(max(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES, HOLD_CYCLES)+1).
- lock_loss_cnt saturates at all-ones and never wraps.

Optional Feature:
- Macro: PLL_RST_LOCK_LOSS_CNT_EN.
- Defined: lock_loss_cnt counter is implemented as described above.
- Undefined: the counter logic is removed and lock_loss_cnt is tied to 0. The port is always present; all other behaviour is identical.

Decomposition:
- Package pll_rst_pkg holds:
  - state enum (WAIT_LOCK, STABLE, REL_CORE, RUN, HOLD).
  - rst_cause_e enum (CAUSE_POR=2'd0, CAUSE_LOCK_LOSS=2'd1, CAUSE_EXT=2'd2).
- One sub-module: sync_ff, a parameterized N-stage synchronizer with async active-low reset, used for pll_locked.

Test Plan (SYNC_STAGES=2, LOCK_STABLE_CYCLES=16, STAGE_GAP_CYCLES=4, HOLD_CYCLES=8, CNT_W=2):
- Power-up, pll_locked=1 throughout -> sys_rst_n rises at edge 18, periph_rst_n and ready at edge 22, rst_cause=0.
- pll_locked drops for 1 cycle at stable cycle 10 -> no release; sys_rst_n rises 16 cycles after the synchronized re-lock; lock_loss_cnt stays 0.
- In RUN, pll_locked=0 -> all resets assert 3 edges later (2 sync + 1); rst_cause=1; lock_loss_cnt=1; re-lock releases per first scenario timing.
- In RUN, ext_rst_req pulse -> resets asserted next edge; held 8 cycles; sys_rst_n returns 16+1 cycles later if locked; rst_cause=2.
- ext_rst_req and locked_s falling on the same cycle -> state WAIT_LOCK, rst_cause=1.
- Four lock-loss events from RUN -> lock_loss_cnt reads 3 (saturated); with the macro undefined it reads 0. rst_n pulse mid-REL_CORE -> all outputs 0 immediately and rst_cause=0.
